// File: rtl/ct_hpcp_ovf_int_ctrl_pkg.sv
// rtl/ct_hpcp_ovf_int_ctrl_pkg.sv - shared hpcp constants and interrupt FSM encoding
//
// Purpose : Shared hpcp constants for the overflow/interrupt slice:
//           - counter count
//           - interrupt FSM state encoding
// Contents: HPCP_NUM_CNT, hpcp_int_state_e
package ct_hpcp_ovf_int_ctrl_pkg;

  localparam int HPCP_NUM_CNT = 32;

  // 2'b11 is unused and is treated as IDLE by the FSM.
  typedef enum logic [1:0] {
    HPCP_INT_IDLE   = 2'b00,
    HPCP_INT_ASSERT = 2'b01,
    HPCP_INT_GAP    = 2'b10
  } hpcp_int_state_e;

endpackage

// File: rtl/ct_hpcp_cntof_reg.sv
// rtl/ct_hpcp_cntof_reg.sv - one sticky, software-writable overflow status bit
//
// Purpose : Holds one counter's overflow status bit.
//           - a software write may set or clear the bit
//           - an overflow pulse always sets it, even when a write lands in the same cycle
// Ports   : hpcp_clk, cpurst_b (async, active-low)
//           cntof_wen   - software write strobe
//           wdata       - software write data for this bit
//           ovf_pulse   - one-cycle overflow pulse for this counter
//           cntof_bit   - status bit
module ct_hpcp_cntof_reg (
  input  logic hpcp_clk,
  input  logic cpurst_b,
  input  logic cntof_wen,
  input  logic wdata,
  input  logic ovf_pulse,
  output logic cntof_bit
);

  logic cntof_nxt;

  // OR-ing the pulse in after the write mux means an overflow is never lost.
  assign cntof_nxt = (cntof_wen ? wdata : cntof_bit) | ovf_pulse;

  always_ff @(posedge hpcp_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      cntof_bit <= 1'b0;
    end else begin
      cntof_bit <= cntof_nxt;
    end
  end

endmodule

// File: rtl/ct_hpcp_ovf_int_ctrl.sv
// rtl/ct_hpcp_ovf_int_ctrl.sv - HPCP overflow status and PMU overflow interrupt controller
//
// Purpose : Captures per-counter overflow pulses into the overflow status register.
//           Qualifies the status with cntinten and drives a level interrupt request.
//           The interrupt always drops for at least one cycle between assertions,
//           so an edge-sensitive receiver sees every new request.
// Ports   : hpcp_clk, cpurst_b (async, active-low)
//           cntinten[NUM_CNT]         - per-counter interrupt enable
//           cnt_ovf_pulse[NUM_CNT]    - per-counter wrap pulse
//           cntof_wen, hpcp_wdata     - software write to the overflow status
//           freeze_on_ovf_en          - stop counters while the interrupt is asserted
//           cntof_value[NUM_CNT]      - overflow status register
//           hpcp_int_vld              - registered interrupt request
//           hpcp_cnt_freeze           - registered counter freeze request
module ct_hpcp_ovf_int_ctrl
  import ct_hpcp_ovf_int_ctrl_pkg::*;
#(
  parameter int NUM_CNT = HPCP_NUM_CNT
) (
  input  logic               hpcp_clk,
  input  logic               cpurst_b,
  input  logic [NUM_CNT-1:0] cntinten,
  input  logic [NUM_CNT-1:0] cnt_ovf_pulse,
  input  logic               cntof_wen,
  input  logic [NUM_CNT-1:0] hpcp_wdata,
  input  logic               freeze_on_ovf_en,
  output logic [NUM_CNT-1:0] cntof_value,
  output logic               hpcp_int_vld,
  output logic               hpcp_cnt_freeze
);

  hpcp_int_state_e cur_state;
  hpcp_int_state_e next_state;
  logic            pending;
  logic            int_vld_nxt;
  logic            cnt_freeze_nxt;

  for (genvar gi = 0; gi < NUM_CNT; gi++) begin : g_cntof
    ct_hpcp_cntof_reg u_cntof_reg (
      .hpcp_clk  (hpcp_clk),
      .cpurst_b  (cpurst_b),
      .cntof_wen (cntof_wen),
      .wdata     (hpcp_wdata[gi]),
      .ovf_pulse (cnt_ovf_pulse[gi]),
      .cntof_bit (cntof_value[gi])
    );
  end

  // cntinten is used live so enable changes act in the same cycle.
  assign pending = |(cntof_value & cntinten);

  always_ff @(posedge hpcp_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      cur_state <= HPCP_INT_IDLE;
    end else begin
      cur_state <= next_state;
    end
  end

  always_comb begin
    next_state = HPCP_INT_IDLE;
    case (cur_state)
      HPCP_INT_ASSERT: next_state = pending ? HPCP_INT_ASSERT : HPCP_INT_GAP;
      // GAP lasts one cycle, then re-arms straight away if still pending.
      HPCP_INT_GAP:    next_state = pending ? HPCP_INT_ASSERT : HPCP_INT_IDLE;
      // IDLE and the unused encoding behave alike.
      default:         next_state = pending ? HPCP_INT_ASSERT : HPCP_INT_IDLE;
    endcase
  end

  // Outputs are registered copies of the next-state decode.
  // They are therefore high exactly while the state register holds ASSERT.
  assign int_vld_nxt    = (next_state == HPCP_INT_ASSERT);
  assign cnt_freeze_nxt = int_vld_nxt & freeze_on_ovf_en;

  always_ff @(posedge hpcp_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      hpcp_int_vld    <= 1'b0;
      hpcp_cnt_freeze <= 1'b0;
    end else begin
      hpcp_int_vld    <= int_vld_nxt;
      hpcp_cnt_freeze <= cnt_freeze_nxt;
    end
  end

endmodule

// File: tb/tb_ct_hpcp_ovf_int_ctrl.sv
// tb/tb_ct_hpcp_ovf_int_ctrl.sv - scoreboard bench for ct_hpcp_ovf_int_ctrl
module tb_ct_hpcp_ovf_int_ctrl;

  localparam int N = 32;

  logic           hpcp_clk;
  logic           cpurst_b;
  logic [N-1:0]   cntinten;
  logic [N-1:0]   cnt_ovf_pulse;
  logic           cntof_wen;
  logic [N-1:0]   hpcp_wdata;
  logic           freeze_on_ovf_en;
  logic [N-1:0]   cntof_value;
  logic           hpcp_int_vld;
  logic           hpcp_cnt_freeze;

  typedef struct {
    string        name;
    logic [N-1:0] of;
    logic         iv;
    logic         fz;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp;
  int   n_bad;
  logic mon_en;

  ct_hpcp_ovf_int_ctrl #(.NUM_CNT(N)) dut (
    .hpcp_clk         (hpcp_clk),
    .cpurst_b         (cpurst_b),
    .cntinten         (cntinten),
    .cnt_ovf_pulse    (cnt_ovf_pulse),
    .cntof_wen        (cntof_wen),
    .hpcp_wdata       (hpcp_wdata),
    .freeze_on_ovf_en (freeze_on_ovf_en),
    .cntof_value      (cntof_value),
    .hpcp_int_vld     (hpcp_int_vld),
    .hpcp_cnt_freeze  (hpcp_cnt_freeze)
  );

  initial begin
    hpcp_clk = 1'b0;
    forever #5 hpcp_clk = ~hpcp_clk;
  end

  // Monitor: every clock edge and every asynchronous reset assertion is an
  // observation point; each one consumes exactly one expectation.
  initial begin
    wait (mon_en === 1'b1);
    forever begin
      @(posedge hpcp_clk or negedge cpurst_b);
      #1;
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        n_cmp = n_cmp + 3;
        if (cntof_value !== e.of) begin
          n_bad = n_bad + 1;
          $display("FAIL %s cntof_value got %h expected %h", e.name, cntof_value, e.of);
        end
        if (hpcp_int_vld !== e.iv) begin
          n_bad = n_bad + 1;
          $display("FAIL %s hpcp_int_vld got %b expected %b", e.name, hpcp_int_vld, e.iv);
        end
        if (hpcp_cnt_freeze !== e.fz) begin
          n_bad = n_bad + 1;
          $display("FAIL %s hpcp_cnt_freeze got %b expected %b", e.name, hpcp_cnt_freeze, e.fz);
        end
      end
    end
  end

  // One cycle of stimulus; expectation is the output seen after the next rising edge.
  task automatic step(input string nm, input logic wen, input logic [N-1:0] wd,
                      input logic [N-1:0] pulse, input logic [N-1:0] ie, input logic fe,
                      input logic [N-1:0] e_of, input logic e_iv, input logic e_fz);
    exp_t e;
    @(negedge hpcp_clk);
    cpurst_b         = 1'b1;
    cntof_wen        = wen;
    hpcp_wdata       = wd;
    cnt_ovf_pulse    = pulse;
    cntinten         = ie;
    freeze_on_ovf_en = fe;
    e.name = nm; e.of = e_of; e.iv = e_iv; e.fz = e_fz;
    exp_q.push_back(e);
  endtask

  // Reset asserted mid-cycle: outputs must drop at once, then stay cleared
  // across the following clock edge even with an overflow pulse presented.
  task automatic mid_reset();
    exp_t e;
    @(negedge hpcp_clk);
    cnt_ovf_pulse = 32'h8;
    cntof_wen     = 1'b0;
    e.name = "async_reset_now"; e.of = '0; e.iv = 1'b0; e.fz = 1'b0;
    exp_q.push_back(e);
    e.name = "reset_held_edge";
    exp_q.push_back(e);
    #2 cpurst_b = 1'b0;
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; mon_en = 1'b0;
    cpurst_b = 1'b0; cntinten = '0; cnt_ovf_pulse = '0; cntof_wen = 1'b0;
    hpcp_wdata = '0; freeze_on_ovf_en = 1'b0;
    repeat (2) @(negedge hpcp_clk);
    mon_en = 1'b1;
    begin
      exp_t e;
      e.name = "reset_state"; e.of = '0; e.iv = 1'b0; e.fz = 1'b0;
      exp_q.push_back(e);
      e.name = "reset_state_2";
      exp_q.push_back(e);
      repeat (2) @(negedge hpcp_clk);
    end

    //   name            wen wdata       pulse       inten       fe   cntof       iv  fz
    step("ovf3_set",     0, 32'h0,     32'h8,      32'h8,      1, 32'h8,      0, 0);
    step("ovf3_int",     0, 32'h0,     32'h0,      32'h8,      1, 32'h8,      1, 1);
    step("ovf5_masked",  0, 32'h0,     32'h20,     32'h8,      1, 32'h28,     1, 1);
    step("hold_28",      0, 32'h0,     32'h0,      32'h8,      1, 32'h28,     1, 1);
    step("wr0_ovf3_same",1, 32'h0,     32'h8,      32'h8,      1, 32'h8,      1, 1);
    step("hold_8",       0, 32'h0,     32'h0,      32'h8,      1, 32'h8,      1, 1);
    step("clear_T",      1, 32'h0,     32'h0,      32'h8,      1, 32'h0,      1, 1);
    step("clear_gap",    0, 32'h0,     32'h0,      32'h8,      1, 32'h0,      0, 0);
    step("clear_idle",   0, 32'h0,     32'h0,      32'h8,      1, 32'h0,      0, 0);
    step("idle_hold",    0, 32'h0,     32'h0,      32'h8,      1, 32'h0,      0, 0);
    step("reovf_set",    0, 32'h0,     32'h8,      32'h8,      1, 32'h8,      0, 0);
    step("reovf_int",    0, 32'h0,     32'h0,      32'h8,      1, 32'h8,      1, 1);
    step("clr2_T",       1, 32'h0,     32'h0,      32'h8,      1, 32'h0,      1, 1);
    step("clr2_newovf",  0, 32'h0,     32'h8,      32'h8,      1, 32'h8,      0, 0);
    step("gap_rearm",    0, 32'h0,     32'h0,      32'h8,      1, 32'h8,      1, 1);
    step("rearm_hold",   0, 32'h0,     32'h0,      32'h8,      1, 32'h8,      1, 1);
    step("frz_off",      0, 32'h0,     32'h0,      32'h8,      0, 32'h8,      1, 0);
    step("frz_off_hold", 0, 32'h0,     32'h0,      32'h8,      0, 32'h8,      1, 0);
    step("inten_drop",   0, 32'h0,     32'h0,      32'h0,      0, 32'h8,      0, 0);
    step("inten_idle",   0, 32'h0,     32'h0,      32'h0,      0, 32'h8,      0, 0);
    step("inten_set",    0, 32'h0,     32'h0,      32'h8,      0, 32'h8,      1, 0);
    step("frz_on",       0, 32'h0,     32'h0,      32'h8,      1, 32'h8,      1, 1);
    step("sw_set_100",   1, 32'h100,   32'h0,      32'h8,      1, 32'h100,    1, 1);
    step("sw_set_gap",   0, 32'h0,     32'h0,      32'h8,      1, 32'h100,    0, 0);
    step("sw_set_idle",  0, 32'h0,     32'h0,      32'h8,      1, 32'h100,    0, 0);
    step("en_bit8",      0, 32'h0,     32'h0,      32'h108,    1, 32'h100,    1, 1);
    mid_reset();
    step("post_reset",   0, 32'h0,     32'h0,      32'h108,    1, 32'h0,      0, 0);
    step("post_ovf3",    0, 32'h0,     32'h8,      32'h108,    1, 32'h8,      0, 0);
    step("post_int",     0, 32'h0,     32'h0,      32'h108,    1, 32'h8,      1, 1);

    @(negedge hpcp_clk);
    cnt_ovf_pulse = '0;
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge hpcp_clk);
    if (exp_q.size() != 0) begin
      n_cmp = n_cmp + 1;
      n_bad = n_bad + 1;
      $display("FAIL drain %0d expectations left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ct_hpcp_ovf_int_ctrl.md
# ct_hpcp_ovf_int_ctrl

Overflow-status and interrupt controller for the hardware performance counter (HPCP) unit. It captures per-counter overflow pulses into a sticky, software-writable overflow status register. It qualifies those bits with the per-counter interrupt-enable bits from the cntinten registers and drives one PMU overflow interrupt request to the core. It sits downstream of the counter array and the cntinten registers, and upstream of the core interrupt controller.

## Interface
- NUM_CNT, 32 — number of counters, and the width of every per-counter bus.
- hpcp_clk  in  1  clock.
- cpurst_b  in  1  reset, asynchronous, active-low.
- cntinten  in  NUM_CNT  per-counter interrupt enable; bit x comes from that counter's cntinten register.
- cnt_ovf_pulse  in  NUM_CNT  one-cycle pulse when counter x wraps.
- cntof_wen  in  1  software write strobe for the overflow status register.
- hpcp_wdata  in  NUM_CNT  software write data.
- freeze_on_ovf_en  in  1  when high, request counters to stop while an interrupt is asserted.
- cntof_value  out  NUM_CNT  overflow status register; readable by software.
- hpcp_int_vld  out  1  PMU overflow interrupt request; level, registered.
- hpcp_cnt_freeze  out  1  counter-freeze request to the counter array; registered.

## Operation
- Overflow status update, per bit x:
  - Next value = (cntof_wen ? hpcp_wdata[x] : cntof_value[x]) | cnt_ovf_pulse[x].
  - When a write and an overflow pulse land on the same bit in the same cycle, the overflow wins; no overflow is ever lost.
  - Software may set bits as well as clear them.
- pending = |(cntof_value & cntinten). It is combinational and internal.
- Interrupt FSM, three states:
  - IDLE: interrupt output 0. Go to ASSERT when pending = 1.
  - ASSERT: interrupt output 1. Go to GAP when pending = 0 (status cleared or enable dropped).
  - GAP: interrupt output 0 for exactly one cycle, so an edge-sensitive receiver sees a falling edge. Then go to ASSERT if pending = 1, otherwise to IDLE.
- hpcp_int_vld = registered (next_state == ASSERT), so it is high exactly while the state is ASSERT.
- hpcp_cnt_freeze = registered (next_state == ASSERT) & freeze_on_ovf_en. It changes in the same cycle as hpcp_int_vld.
- Changes to cntinten take effect immediately through pending; no internal copy of cntinten is kept.
- Reset values:
  - cntof_value = 0.
  - hpcp_int_vld = 0.
  - hpcp_cnt_freeze = 0.
  - FSM state = IDLE.
- Reset mid-operation: an asynchronous assert forces all of the above immediately, including dropping hpcp_int_vld. There is no interaction with the preceding state.
- Unused encodings of the FSM state decode to IDLE.

## Timing
- Overflow pulse in cycle T: cntof_value bit set from T+1, hpcp_int_vld high from T+2 (given the enable bit is set).
- Software clear write in cycle T: status bit low from T+1, pending low in T+1, hpcp_int_vld low from T+2.
  - If a new overflow arrives during GAP, hpcp_int_vld is re-asserted no earlier than T+3.
- Enable bit set in cycle T while its status bit is already 1: hpcp_int_vld high from T+1.
- Minimum low time of hpcp_int_vld between two assertions: 1 cycle.
- A write with hpcp_wdata = 0 while the interrupt is asserted and overflows keep arriving keeps pending high. The interrupt does not drop in that case, which is the required behaviour.

## Structure
- Shared hpcp package holds:
  - HPCP_NUM_CNT = 32.
  - FSM state encoding: IDLE = 2'b00, ASSERT = 2'b01, GAP = 2'b10.
- Sub-module ct_hpcp_cntof_reg: one status bit (wen, wdata, ovf pulse in; status bit out), instantiated NUM_CNT times by generate.
- The top level contains the reduction, the FSM and the output flops.

## Test plan
- Reset: assert cpurst_b low mid-run with hpcp_int_vld = 1 → all outputs 0 immediately; after release, IDLE and cntof_value = 0.
- cntinten = 0x8, pulse cnt_ovf_pulse[3] at T → cntof_value = 0x8 at T+1, hpcp_int_vld = 1 at T+2. Pulse bit 5 with cntinten[5] = 0 → status 0x28, interrupt unaffected.
- Interrupt asserted, write hpcp_wdata = 0 with cntof_wen at T → cntof_value = 0 at T+1, hpcp_int_vld = 0 at T+2, state passes GAP then IDLE.
- Same-cycle cntof_wen (wdata = 0) and cnt_ovf_pulse[3] with cntinten[3] = 1 → cntof_value[3] stays 1, hpcp_int_vld stays 1.
- Clear at T, then new enabled overflow at T+1 → hpcp_int_vld low for exactly one cycle (T+2), high again at T+3.
- freeze_on_ovf_en = 1 with an enabled overflow → hpcp_cnt_freeze tracks hpcp_int_vld cycle-exactly. With freeze_on_ovf_en = 0 → hpcp_cnt_freeze stays 0.
